gray_wdt_array: RTL and testbench

GRAY_WDT_ARRAY -- requirements
Module: gray_wdt_array

---
 rtl/wdt_pkg.sv | 24 ++
 rtl/wdt_chan.sv | 102 ++++++++++
 rtl/gray_wdt_array.sv | 58 +++++
 tb/tb_gray_wdt_array.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wdt_pkg.sv
// Shared types and Gray-code helpers for the heartbeat watchdog array.
// The helpers work on 8-bit vectors; narrower codes are zero-extended by the caller.
package wdt_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      TRACK = 2'd1,
      ERROR = 2'd2
   } wdt_state_e;

   function automatic logic [7:0] bin2gray(input logic [7:0] b);
      return b ^ (b >> 1);
   endfunction

   function automatic logic [7:0] gray2bin(input logic [7:0] g);
      logic [7:0] b;
      b[7] = g[7];
      for (int i = 6; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

endpackage

// File: rtl/wdt_chan.sv
// One heartbeat channel: registers the Gray heartbeat, checks each new sample
// for hold / legal advance / illegal jump, counts laps and a hold timeout.
module wdt_chan
   import wdt_pkg::*;
#(
   parameter int GW        = 3,
   parameter int TIMEOUT   = 6500000,
   parameter int HEAL_LAPS = 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [GW-1:0] hb,
   input  logic          fault_clr,
   output logic          health,
   output logic          fault
);

   localparam int            TW          = $clog2(TIMEOUT + 1);
   localparam logic [7:0]    CODE_MASK   = 8'((1 << GW) - 1);
   localparam logic [GW-1:0] LAST_CODE   = GW'(bin2gray(CODE_MASK));
   localparam logic [TW-1:0] TMO_LAST    = TW'(TIMEOUT - 1);
   localparam logic [3:0]    HEAL_TARGET = 4'(HEAL_LAPS);

   wdt_state_e    state;
   logic [GW-1:0] hb_d1;
   logic [GW-1:0] prev;
   logic [TW-1:0] tmo_cnt;
   logic [3:0]    lap_cnt;
   logic [GW-1:0] successor;
   logic          is_hold;
   logic          is_adv;
   logic          is_lap;
   logic          to_error;

   assign successor = GW'(bin2gray((gray2bin(8'(prev)) + 8'd1) & CODE_MASK));
   assign is_hold   = (hb_d1 == prev);
   assign is_adv    = (hb_d1 == successor);
   assign is_lap    = (prev == LAST_CODE);

   // A timeout and an illegal value both funnel into this one term, so they
   // can only ever produce a single ERROR entry.
   assign to_error  = (state == TRACK) && (is_hold ? (tmo_cnt == TMO_LAST) : !is_adv);

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         hb_d1   <= '0;
         prev    <= '0;
         tmo_cnt <= '0;
         lap_cnt <= '0;
         health  <= 1'b0;
         fault   <= 1'b0;
      end else begin
         hb_d1 <= hb;
         if (to_error) begin
            state   <= ERROR;
            lap_cnt <= '0;
            tmo_cnt <= '0;
            health  <= 1'b0;
            fault   <= 1'b1;
         end else begin
            if (fault_clr) begin
               fault <= 1'b0;
            end
            unique case (state)
               IDLE: begin
                  if (hb_d1 == '0) begin
                     state   <= TRACK;
                     prev    <= '0;
                     tmo_cnt <= '0;
                  end
               end
               TRACK: begin
                  if (is_hold) begin
                     tmo_cnt <= tmo_cnt + TW'(1);
                  end else begin
                     prev    <= hb_d1;
                     tmo_cnt <= '0;
                     if (is_lap && (lap_cnt != HEAL_TARGET)) begin
                        lap_cnt <= lap_cnt + 4'd1;
                        if ((lap_cnt + 4'd1) == HEAL_TARGET) begin
                           health <= 1'b1;
                        end
                     end
                  end
               end
               ERROR: begin
                  if (hb_d1 == '0) begin
                     state   <= TRACK;
                     prev    <= '0;
                     tmo_cnt <= '0;
                  end else begin
                     state <= IDLE;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: rtl/gray_wdt_array.sv
// Array of NCH Gray-heartbeat watchdogs plus a registered aggregate health flag.
// Define WDT_MAJORITY_VOTE_EN for a strict-majority vote instead of all-healthy.
module gray_wdt_array #(
   parameter int NCH       = 4,
   parameter int GW        = 3,
   parameter int TIMEOUT   = 6500000,
   parameter int HEAL_LAPS = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NCH*GW-1:0] hb,
   input  logic [NCH-1:0]    fault_clr,
   output logic [NCH-1:0]    health,
   output logic [NCH-1:0]    fault,
   output logic              majority_ok
);

   for (genvar i = 0; i < NCH; i++) begin : g_chan
      wdt_chan #(
         .GW        (GW),
         .TIMEOUT   (TIMEOUT),
         .HEAL_LAPS (HEAL_LAPS)
      ) u_chan (
         .clk       (clk),
         .reset     (reset),
         .hb        (hb[i*GW +: GW]),
         .fault_clr (fault_clr[i]),
         .health    (health[i]),
         .fault     (fault[i])
      );
   end

   logic vote;

`ifdef WDT_MAJORITY_VOTE_EN
   logic [4:0] healthy_cnt;

   always_comb begin
      healthy_cnt = '0;
      for (int i = 0; i < NCH; i++) begin
         healthy_cnt = healthy_cnt + 5'(health[i]);
      end
   end

   assign vote = (healthy_cnt > 5'(NCH / 2));
`else
   assign vote = &health;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         majority_ok <= 1'b0;
      end else begin
         majority_ok <= vote;
      end
   end

endmodule

// File: tb/tb_gray_wdt_array.sv
// Self-checking bench for gray_wdt_array: directed scenarios plus random heartbeats,
// every cycle compared against a behavioural per-channel model.
module tb_gray_wdt_array;

   localparam int NCH       = 4;
   localparam int GW        = 3;
   localparam int TIMEOUT   = 16;
   localparam int HEAL_LAPS = 2;
   localparam int NCODES    = 1 << GW;
   localparam int M_IDLE    = 0;
   localparam int M_TRACK   = 1;
   localparam int M_ERROR   = 2;

   logic              clk = 1'b0;
   logic              reset;
   logic [NCH*GW-1:0] hb;
   logic [NCH-1:0]    fault_clr;
   logic [NCH-1:0]    health;
   logic [NCH-1:0]    fault;
   logic              majority_ok;
   logic [GW-1:0]     hb_ch [NCH];

   int errors = 0;
   int checks = 0;

   int            m_mode [NCH];
   int            m_pos  [NCH];
   int            m_tmo  [NCH];
   int            m_lap  [NCH];
   logic [GW-1:0] m_hbd1 [NCH];
   logic [NCH-1:0] m_health;
   logic [NCH-1:0] m_fault;
   logic           m_maj;

   int g_pos  [NCH];
   int g_hold [NCH];

   gray_wdt_array #(
      .NCH       (NCH),
      .GW        (GW),
      .TIMEOUT   (TIMEOUT),
      .HEAL_LAPS (HEAL_LAPS)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .hb          (hb),
      .fault_clr   (fault_clr),
      .health      (health),
      .fault       (fault),
      .majority_ok (majority_ok)
   );

   always #5 clk = ~clk;

   always_comb begin
      hb = '0;
      for (int i = 0; i < NCH; i++) begin
         hb[i*GW +: GW] = hb_ch[i];
      end
   end

   function automatic int grayOf(input int i);
      return i ^ (i >> 1);
   endfunction

   function automatic logic voteOf(input logic [NCH-1:0] h);
`ifdef WDT_MAJORITY_VOTE_EN
      return $countones(h) > (NCH / 2);
`else
      return h == {NCH{1'b1}};
`endif
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
      end
   endtask

   // Reference: each channel tracks its position in the Gray cycle as a plain index.
   task automatic modelStep();
      logic maj_next;
      if (reset) begin
         for (int c = 0; c < NCH; c++) begin
            m_mode[c] = M_IDLE;
            m_pos[c]  = 0;
            m_tmo[c]  = 0;
            m_lap[c]  = 0;
            m_hbd1[c] = '0;
         end
         m_health = '0;
         m_fault  = '0;
         m_maj    = 1'b0;
         return;
      end
      maj_next = voteOf(m_health);
      for (int c = 0; c < NCH; c++) begin
         int  d;
         bit  err;
         d   = int'(m_hbd1[c]);
         err = 1'b0;
         case (m_mode[c])
            M_IDLE: begin
               if (d == 0) begin
                  m_mode[c] = M_TRACK;
                  m_pos[c]  = 0;
                  m_tmo[c]  = 0;
               end
            end
            M_TRACK: begin
               if (d == grayOf(m_pos[c])) begin
                  m_tmo[c]++;
                  if (m_tmo[c] >= TIMEOUT) err = 1'b1;
               end else if (d == grayOf((m_pos[c] + 1) % NCODES)) begin
                  if (m_pos[c] == NCODES - 1 && m_lap[c] < HEAL_LAPS) m_lap[c]++;
                  m_pos[c] = (m_pos[c] + 1) % NCODES;
                  m_tmo[c] = 0;
               end else begin
                  err = 1'b1;
               end
            end
            default: begin
               if (d == 0) begin
                  m_mode[c] = M_TRACK;
                  m_pos[c]  = 0;
                  m_tmo[c]  = 0;
               end else begin
                  m_mode[c] = M_IDLE;
               end
            end
         endcase
         if (err) begin
            m_mode[c] = M_ERROR;
            m_lap[c]  = 0;
            m_tmo[c]  = 0;
         end
         m_health[c] = (m_mode[c] == M_TRACK) && (m_lap[c] == HEAL_LAPS);
         if (err) m_fault[c] = 1'b1;
         else if (fault_clr[c]) m_fault[c] = 1'b0;
         m_hbd1[c] = hb_ch[c];
      end
      m_maj = maj_next;
   endtask

   task automatic applyStimulus();
      @(posedge clk);
      modelStep();
      #1;
      checkOutput("health", 32'(health), 32'(m_health));
      checkOutput("fault", 32'(fault), 32'(m_fault));
      checkOutput("majority_ok", 32'(majority_ok), 32'(m_maj));
   endtask

   task automatic driveLaps(input logic [NCH-1:0] mask, input int laps, input int hold);
      for (int l = 0; l < laps; l++) begin
         for (int p = 0; p < NCODES; p++) begin
            for (int h = 0; h < hold; h++) begin
               for (int c = 0; c < NCH; c++) if (mask[c]) hb_ch[c] = GW'(grayOf(p));
               applyStimulus();
            end
         end
      end
      for (int h = 0; h < hold; h++) begin
         for (int c = 0; c < NCH; c++) if (mask[c]) hb_ch[c] = '0;
         applyStimulus();
      end
   endtask

   task automatic pulseReset();
      reset = 1'b1;
      for (int c = 0; c < NCH; c++) hb_ch[c] = '0;
      applyStimulus();
      reset = 1'b0;
   endtask

   initial begin
      reset     = 1'b1;
      fault_clr = '0;
      for (int c = 0; c < NCH; c++) hb_ch[c] = '0;
      applyStimulus();
      applyStimulus();
      checkOutput("reset_health", 32'(health), 32'h0);
      checkOutput("reset_fault", 32'(fault), 32'h0);
      checkOutput("reset_majority", 32'(majority_ok), 32'h0);
      reset = 1'b0;

      // Two clean laps on ch0 heal it.
      driveLaps(4'b0001, 2, 4);
      checkOutput("ch0_healed", 32'(health[0]), 32'h1);
      checkOutput("ch0_no_fault", 32'(fault[0]), 32'h0);

      // Skipping a code on ch0 is an error.
      for (int h = 0; h < 4; h++) begin hb_ch[0] = 3'b001; applyStimulus(); end
      hb_ch[0] = 3'b010;
      applyStimulus();
      applyStimulus();
      checkOutput("ch0_jump_health", 32'(health[0]), 32'h0);
      checkOutput("ch0_jump_fault", 32'(fault[0]), 32'h1);
      applyStimulus();
      checkOutput("ch0_idle_health", 32'(health[0]), 32'h0);

      // ch1: heal, then stall on 011 until the hold timeout fires.
      driveLaps(4'b0010, 2, 4);
      checkOutput("ch1_healed", 32'(health[1]), 32'h1);
      hb_ch[1]  = 3'b001;
      fault_clr = 4'b0010;
      applyStimulus();
      fault_clr = '0;
      for (int h = 0; h < 3; h++) applyStimulus();
      hb_ch[1] = 3'b011;
      for (int h = 0; h < 20; h++) applyStimulus();
      checkOutput("ch1_timeout_fault", 32'(fault[1]), 32'h1);
      checkOutput("ch1_timeout_health", 32'(health[1]), 32'h0);

      // Clear alone wins; a clear coinciding with a new error loses.
      fault_clr = 4'b0010;
      applyStimulus();
      fault_clr = '0;
      checkOutput("ch1_clear", 32'(fault[1]), 32'h0);
      hb_ch[1] = 3'b000;
      for (int h = 0; h < 3; h++) applyStimulus();
      hb_ch[1] = 3'b011;
      applyStimulus();
      fault_clr = 4'b0010;
      applyStimulus();
      fault_clr = '0;
      checkOutput("ch1_set_beats_clear", 32'(fault[1]), 32'h1);
      applyStimulus();
      fault_clr = 4'b0010;
      applyStimulus();
      fault_clr = '0;
      checkOutput("ch1_clear_again", 32'(fault[1]), 32'h0);

      // All channels healthy, reset pulse, then re-heal needs two full laps.
      pulseReset();
      driveLaps(4'b1111, 2, 4);
      checkOutput("all_healed", 32'(health), 32'hf);
      checkOutput("all_majority", 32'(majority_ok), 32'h1);
      reset = 1'b1;
      applyStimulus();
      reset = 1'b0;
      checkOutput("midrun_reset_health", 32'(health), 32'h0);
      checkOutput("midrun_reset_majority", 32'(majority_ok), 32'h0);
      driveLaps(4'b1111, 1, 4);
      checkOutput("one_lap_not_healed", 32'(health), 32'h0);
      driveLaps(4'b1111, 1, 4);
      checkOutput("two_laps_healed", 32'(health), 32'hf);

      // Three of four healthy, then two of four.
      pulseReset();
      hb_ch[3] = 3'b101;
      driveLaps(4'b0111, 2, 4);
      checkOutput("three_healthy", 32'(health), 32'h7);
`ifdef WDT_MAJORITY_VOTE_EN
      checkOutput("vote_3_of_4", 32'(majority_ok), 32'h1);
`else
      checkOutput("vote_3_of_4", 32'(majority_ok), 32'h0);
`endif
      hb_ch[2] = 3'b011;
      for (int h = 0; h < 3; h++) applyStimulus();
      checkOutput("two_healthy", 32'(health), 32'h3);
      checkOutput("vote_2_of_4", 32'(majority_ok), 32'h0);

      // Random heartbeats: mostly clean advances, occasional glitches and long stalls.
      pulseReset();
      for (int c = 0; c < NCH; c++) begin
         g_pos[c]  = 0;
         g_hold[c] = 0;
      end
      for (int n = 0; n < 3000; n++) begin
         for (int c = 0; c < NCH; c++) begin
            if (g_hold[c] > 0) begin
               g_hold[c]--;
            end else begin
               if ($urandom_range(0, 99) < 3) g_pos[c] = int'($urandom_range(0, NCODES - 1));
               else g_pos[c] = (g_pos[c] + 1) % NCODES;
               g_hold[c] = ($urandom_range(0, 49) == 0) ? 18 : int'($urandom_range(0, 4));
            end
            hb_ch[c]     = GW'(grayOf(g_pos[c]));
            fault_clr[c] = ($urandom_range(0, 7) == 0);
         end
         reset = ($urandom_range(0, 399) == 0);
         applyStimulus();
      end
      reset     = 1'b0;
      fault_clr = '0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
